// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, motion command encodings and
// controller state encoding.
package elevator_pkg;

   localparam int unsigned NFLOORS = 6;
   localparam int unsigned DIR_W   = 2;

   localparam logic [DIR_W-1:0] DIR_UP   = 2'b10;
   localparam logic [DIR_W-1:0] DIR_DOWN = 2'b01;
   localparam logic [DIR_W-1:0] DIR_STOP = 2'b00;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } ctrl_state_t;

   typedef enum logic {
      SWEEP_DOWN = 1'b0,
      SWEEP_UP   = 1'b1
   } sweep_t;

endpackage

// File: rtl/door_timer.sv
// Dwell counter for the open door: load/reload restart a DOOR_CYCLES dwell,
// done flags the final door cycle.
module door_timer #(
   parameter int unsigned DOOR_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic reload,
   input  logic clear,
   output logic done
);

   localparam int unsigned CNT_W = 4;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load || reload) begin
         count <= CNT_W'(DOOR_CYCLES - 1);
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/direction_control.sv
// Collective elevator controller: latches floor calls, sweeps the car in one
// direction while calls remain ahead, and dwells with the door open at each stop.
module direction_control
   import elevator_pkg::*;
#(
   parameter int unsigned DOOR_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NFLOORS-1:0] floorbutton,
   input  logic [NFLOORS-1:0] floor,
   output logic [DIR_W-1:0]   direction,
   output logic               door_open,
   output logic [NFLOORS-1:0] pending,
   output logic               fault
);

   ctrl_state_t        state, state_nxt;
   sweep_t             sweep, sweep_nxt;
   logic [NFLOORS-1:0] above_mask, below_mask;
   logic [NFLOORS-1:0] clear_mask, call_mask;
   logic               arrived, above, below, door_call;
   logic               tmr_load, tmr_reload, tmr_clear, tmr_done;

   // Floors strictly above / below the car, derived from the one-hot position
   always_comb begin
      above_mask = '0;
      below_mask = '0;
      for (int i = 0; i < int'(NFLOORS); i++) begin
         above_mask[i] = |(floor & ((NFLOORS'(1) << i) - NFLOORS'(1)));
         below_mask[i] = |(floor & ~((NFLOORS'(2) << i) - NFLOORS'(1)));
      end
   end

   assign fault   = (floor == '0) || ((floor & (floor - NFLOORS'(1))) != '0);
   assign arrived = |(pending & floor);
   assign above   = |(pending & above_mask);
   assign below   = |(pending & below_mask);

   // A press for the floor being served keeps the door open instead of latching
   assign call_mask = (state == DOOR_OPEN && !fault) ? floor : '0;
   assign door_call = |(floorbutton & call_mask);

   always_comb begin
      state_nxt  = state;
      sweep_nxt  = sweep;
      direction  = DIR_STOP;
      clear_mask = '0;
      tmr_load   = 1'b0;
      tmr_reload = 1'b0;
      tmr_clear  = 1'b0;
      if (fault) begin
         state_nxt = IDLE;
         tmr_clear = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (arrived) begin
                  state_nxt = DOOR_OPEN;
               end else if (above) begin
                  state_nxt = MOVE_UP;
                  sweep_nxt = SWEEP_UP;
               end else if (below) begin
                  state_nxt = MOVE_DOWN;
                  sweep_nxt = SWEEP_DOWN;
               end
            end
            MOVE_UP: begin
               if (arrived)                   state_nxt = DOOR_OPEN;
               else if (floor[NFLOORS-1])     state_nxt = IDLE;
               else                           direction = DIR_UP;
            end
            MOVE_DOWN: begin
               if (arrived)                   state_nxt = DOOR_OPEN;
               else if (floor[0])             state_nxt = IDLE;
               else                           direction = DIR_DOWN;
            end
            DOOR_OPEN: begin
               if (door_call) begin
                  tmr_reload = 1'b1;
               end else if (tmr_done) begin
                  // Keep the current sweep while calls remain ahead, else reverse
                  if (sweep == SWEEP_UP) begin
                     if (above) begin
                        state_nxt = MOVE_UP;
                     end else if (below) begin
                        state_nxt = MOVE_DOWN;
                        sweep_nxt = SWEEP_DOWN;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end else begin
                     if (below) begin
                        state_nxt = MOVE_DOWN;
                     end else if (above) begin
                        state_nxt = MOVE_UP;
                        sweep_nxt = SWEEP_UP;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
         if (state != DOOR_OPEN && state_nxt == DOOR_OPEN) begin
            clear_mask = floor;
            tmr_load   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         sweep     <= SWEEP_UP;
         pending   <= '0;
         door_open <= 1'b0;
      end else begin
         state     <= state_nxt;
         sweep     <= sweep_nxt;
         pending   <= (pending | (floorbutton & ~call_mask)) & ~clear_mask;
         door_open <= (state_nxt == DOOR_OPEN);
      end
   end

   door_timer #(
      .DOOR_CYCLES (DOOR_CYCLES)
   ) u_door_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .reload (tmr_reload),
      .clear  (tmr_clear),
      .done   (tmr_done)
   );

endmodule

// File: tb/tb_direction_control.sv
// Closed-loop bench: a floor-light chain moves the car one floor per cycle
// on the controller's direction; directed scenarios plus scoreboarded random call batches.
module tb_direction_control;
   import elevator_pkg::*;

   localparam int unsigned DOOR_CYCLES = 4;
   localparam int          NFL         = 6;
   localparam int          NBATCH      = 25;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] floorbutton;
   logic [5:0] floor;
   logic [1:0] direction;
   logic       door_open;
   logic [5:0] pending;
   logic       fault;

   logic [5:0] car;
   logic       fault_inj;
   logic [5:0] place_floor;
   int         place_seq;
   int         place_seen;
   logic [1:0] dir_s;

   int   checks, failures, mon_checks, mon_fails;
   logic sb_en;
   int   exp_q[$];
   int   m_floor;
   logic m_sweep;

   assign floor = fault_inj ? 6'b000000 : car;

   always #5 clk = ~clk;

   direction_control #(
      .DOOR_CYCLES (DOOR_CYCLES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .floorbutton (floorbutton),
      .floor       (floor),
      .direction   (direction),
      .door_open   (door_open),
      .pending     (pending),
      .fault       (fault)
   );

   // Floor-light chain: the car follows the command seen during the previous cycle
   initial begin
      car        = 6'b000001;
      place_seen = 0;
      dir_s      = DIR_STOP;
      forever begin
         @(negedge clk);
         dir_s = direction;
         @(posedge clk);
         #1;
         if (place_seq != place_seen) begin
            car        = place_floor;
            place_seen = place_seq;
         end else if (dir_s == DIR_UP) begin
            car = car << 1;
         end else if (dir_s == DIR_DOWN) begin
            car = car >> 1;
         end
      end
   end

   // Scoreboard monitor: every door opening must match the next expected stop
   initial begin
      logic door_q;
      int   dwell;
      int   e;
      mon_checks = 0;
      mon_fails  = 0;
      door_q     = 1'b0;
      dwell      = 0;
      forever begin
         @(negedge clk);
         mon_checks++;
         if (door_open && direction != DIR_STOP) begin
            mon_fails++;
            $display("FAIL door_and_motion: door_open=%0b direction=%b, required direction=00", door_open, direction);
         end
         if (sb_en) begin
            if (door_open && !door_q) begin
               mon_checks++;
               if (exp_q.size() == 0) begin
                  mon_fails++;
                  $display("FAIL sb_extra_stop: door opened at floor=%b, required no stop", floor);
               end else begin
                  e = exp_q.pop_front();
                  if (floor != 6'(1 << e)) begin
                     mon_fails++;
                     $display("FAIL sb_stop_floor: got floor=%b expected %b", floor, 6'(1 << e));
                  end
               end
               dwell = 1;
            end else if (door_open) begin
               dwell++;
            end else if (door_q) begin
               mon_checks++;
               if (dwell != int'(DOOR_CYCLES)) begin
                  mon_fails++;
                  $display("FAIL sb_dwell: got %0d door cycles expected %0d", dwell, DOOR_CYCLES);
               end
            end
         end
         door_q = door_open;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [5:0] b);
      floorbutton = b;
      tick();
      floorbutton = '0;
   endtask

   task automatic place(input logic [5:0] f);
      @(negedge clk);
      place_floor = f;
      place_seq++;
      @(posedge clk);
      #2;
   endtask

   // Runs to the next stop; returns the stop floor, motion cycles and door dwell
   task automatic run_to_stop(input bit wait_edge, output logic [5:0] stop_floor,
                              output int up_c, output int dn_c, output int door_c,
                              output logic [5:0] arr_floor, output logic [1:0] arr_dir);
      int n;
      up_c = 0; dn_c = 0; door_c = 0; n = 0;
      stop_floor = '0; arr_floor = '0; arr_dir = DIR_STOP;
      if (wait_edge) @(negedge clk);
      while (!door_open && n < 200) begin
         if (direction == DIR_UP) up_c++;
         else if (direction == DIR_DOWN) dn_c++;
         arr_floor = floor;
         arr_dir   = direction;
         n++;
         @(negedge clk);
      end
      if (!door_open) begin
         check("stop_timeout", int'(door_open), 1);
         return;
      end
      stop_floor = floor;
      while (door_open && n < 400) begin
         door_c++;
         n++;
         @(negedge clk);
      end
   endtask

   // Reference: collective service order for a batch of calls issued while idle
   task automatic model_batch(input logic [5:0] calls_in);
      logic [5:0] calls;
      logic       pref_up;
      int         up_t, dn_t;
      calls   = calls_in;
      pref_up = 1'b1;
      if (calls[m_floor]) begin
         exp_q.push_back(m_floor);
         calls[m_floor] = 1'b0;
         pref_up = m_sweep;
      end
      while (calls != '0) begin
         up_t = -1;
         dn_t = -1;
         for (int f = NFL - 1; f > m_floor; f--) if (calls[f]) up_t = f;
         for (int f = 0; f < m_floor; f++) if (calls[f]) dn_t = f;
         if ((pref_up && up_t >= 0) || (!pref_up && dn_t < 0)) begin
            m_floor = up_t;
            m_sweep = 1'b1;
         end else begin
            m_floor = dn_t;
            m_sweep = 1'b0;
         end
         exp_q.push_back(m_floor);
         calls[m_floor] = 1'b0;
         pref_up = m_sweep;
      end
   endtask

   initial begin
      logic [5:0] sf, af, pend_or, calls;
      logic [1:0] ad;
      logic       dir_bad;
      int         up, dn, dc, n, fidx;

      checks = 0; failures = 0;
      reset = 1'b0; floorbutton = '0; fault_inj = 1'b0;
      place_seq = 0; place_floor = 6'b000001; sb_en = 1'b0;
      m_floor = 0; m_sweep = 1'b1;

      // Reset state
      place(6'b000001);
      repeat (2) @(negedge clk);
      check("rst_direction", int'(direction), int'(DIR_STOP));
      check("rst_door_open", int'(door_open), 0);
      check("rst_pending", int'(pending), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_state", int'(dut.state), int'(IDLE));
      reset = 1'b1;
      tick();

      // Single up call from the ground floor
      press(6'b100000);
      @(negedge clk);
      check("up_pending_latched", int'(pending), 6'b100000);
      run_to_stop(1'b0, sf, up, dn, dc, af, ad);
      check("up_stop_floor", int'(sf), 6'b100000);
      check("up_dir_cycles", up, 5);
      check("up_down_cycles", dn, 0);
      check("up_arrive_floor", int'(af), 6'b100000);
      check("up_arrive_dir", int'(ad), int'(DIR_STOP));
      check("up_door_cycles", dc, int'(DOOR_CYCLES));
      check("up_pending_clear", int'(pending), 0);
      check("up_state_idle", int'(dut.state), int'(IDLE));

      // Collective sweep: intermediate stop, then continue upward
      place(6'b000001);
      press(6'b100100);
      run_to_stop(1'b1, sf, up, dn, dc, af, ad);
      check("sweep_stop1", int'(sf), 6'b000100);
      check("sweep_up1", up, 2);
      check("sweep_door1", dc, int'(DOOR_CYCLES));
      check("sweep_pending1", int'(pending), 6'b100000);
      run_to_stop(1'b0, sf, up, dn, dc, af, ad);
      check("sweep_stop2", int'(sf), 6'b100000);
      check("sweep_up2", up, 3);
      check("sweep_dn2", dn, 0);

      // Reversal after dwell with sweep still up
      place(6'b001000);
      press(6'b001010);
      run_to_stop(1'b1, sf, up, dn, dc, af, ad);
      check("rev_stop1", int'(sf), 6'b001000);
      check("rev_door1", dc, int'(DOOR_CYCLES));
      check("rev_dir_after_dwell", int'(direction), int'(DIR_DOWN));
      check("rev_state_after_dwell", int'(dut.state), int'(MOVE_DOWN));
      run_to_stop(1'b0, sf, up, dn, dc, af, ad);
      check("rev_stop2", int'(sf), 6'b000010);
      check("rev_dn2", dn, 2);
      check("rev_up2", up, 0);

      // Call at the current floor, then a re-press that extends the dwell
      place(6'b000100);
      press(6'b000100);
      run_to_stop(1'b1, sf, up, dn, dc, af, ad);
      check("here_stop", int'(sf), 6'b000100);
      check("here_motion", up + dn, 0);
      check("here_door", dc, int'(DOOR_CYCLES));
      press(6'b000100);
      n = 0;
      @(negedge clk);
      while (!door_open && n < 20) begin n++; @(negedge clk); end
      check("here2_door_open", int'(door_open), 1);
      pend_or = pending;
      tick();
      tick();
      press(6'b000100);
      dc = 0; n = 0; dir_bad = 1'b0;
      @(negedge clk);
      while (door_open && n < 20) begin
         dc++;
         n++;
         pend_or = pend_or | pending;
         if (direction != DIR_STOP) dir_bad = 1'b1;
         @(negedge clk);
      end
      check("reload_further_cycles", dc, int'(DOOR_CYCLES));
      check("reload_no_latch", int'(pend_or[2]), 0);
      check("reload_no_motion", int'(dir_bad), 0);

      // Invalid floor code mid-travel
      place(6'b000001);
      press(6'b100000);
      repeat (3) @(negedge clk);
      check("flt_moving", int'(direction), int'(DIR_UP));
      tick();
      fault_inj = 1'b1;
      @(negedge clk);
      check("flt_fault", int'(fault), 1);
      check("flt_direction", int'(direction), int'(DIR_STOP));
      @(negedge clk);
      check("flt_state_idle", int'(dut.state), int'(IDLE));
      check("flt_pending_kept", int'(pending), 6'b100000);
      tick();
      fault_inj = 1'b0;
      run_to_stop(1'b1, sf, up, dn, dc, af, ad);
      check("flt_resume_stop", int'(sf), 6'b100000);
      check("flt_resume_up", up, 3);

      // Asynchronous reset during a dwell drops all calls
      press(6'b000101);
      n = 0;
      @(negedge clk);
      while (!door_open && n < 40) begin n++; @(negedge clk); end
      check("arst_in_door", int'(door_open), 1);
      check("arst_pending_before", int'(pending), 6'b000001);
      #1 reset = 1'b0;
      #1;
      check("arst_door_open", int'(door_open), 0);
      check("arst_pending", int'(pending), 0);
      check("arst_direction", int'(direction), int'(DIR_STOP));
      @(negedge clk);
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("arst_resume_idle", int'(dut.state), int'(IDLE));

      // Random call batches against the collective-service model
      fidx = 0;
      for (int f = 0; f < NFL; f++) if (car[f]) fidx = f;
      m_floor = fidx;
      m_sweep = 1'b1;
      sb_en   = 1'b1;
      for (int b = 0; b < NBATCH; b++) begin
         if ($urandom_range(1, 0) == 1) begin
            fidx = int'($urandom_range(NFL - 1, 0));
            place(6'(1 << fidx));
            m_floor = fidx;
         end
         calls = 6'($urandom_range(63, 1));
         model_batch(calls);
         press(calls);
         n = 0;
         @(negedge clk);
         while ((exp_q.size() != 0 || door_open) && n < 300) begin n++; @(negedge clk); end
         check("rnd_all_served", exp_q.size(), 0);
         check("rnd_pending_empty", int'(pending), 0);
         exp_q.delete();
         tick();
      end
      sb_en = 1'b0;
      tick();

      checks   += mon_checks;
      failures += mon_fails;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/direction_control.md
DIRECTION_CONTROL -- requirements
Module: direction_control

Interface
REQ-001 Parameter DOOR_CYCLES, default 4: number of clock cycles door_open is held at each stop; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 floorbutton  input  6  per-floor call requests, bit 0 = ground floor; a bit high for one or more cycles registers a call.
REQ-005 floor  input  6  one-hot current car position from the floor-light chain; bit 0 = ground floor.
REQ-006 direction  output  2  motion command to the floor-light chain: 2'b10 up, 2'b01 down, 2'b00 stop; 2'b11 is never driven.
REQ-007 door_open  output  1  high while the car dwells at a served floor.
REQ-008 pending  output  6  latched outstanding calls, one bit per floor.
REQ-009 fault  output  1  high in any cycle in which floor is not exactly one-hot.

Function
REQ-010 Pending register update SHALL be pending <= (pending | floorbutton) & ~clear_mask, with the new call visible one cycle after the press.
REQ-011 clear_mask SHALL equal floor on the edge that enters DOOR_OPEN and SHALL be zero otherwise.
REQ-012 A call for the current floor arriving during DOOR_OPEN SHALL NOT be latched and SHALL reload the dwell counter to DOOR_CYCLES.
REQ-013 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, plus a 1-bit sweep register (UP/DOWN) holding the last travel direction.
REQ-014 "arrived" = |(pending & floor); "above" = any pending bit higher than the floor bit; "below" = any pending bit lower than it.
REQ-015 IDLE: arrived -> DOOR_OPEN; else above -> MOVE_UP (sweep=UP); else below -> MOVE_DOWN (sweep=DOWN); else stay; above takes priority over below.
REQ-016 MOVE_UP/MOVE_DOWN: arrived -> DOOR_OPEN next edge; otherwise remain in the moving state.
REQ-017 direction SHALL be combinational: 2'b10 in MOVE_UP and 2'b01 in MOVE_DOWN when not arrived; 2'b00 in every other case. The car therefore stops in the same cycle its floor bit matches a call.
REQ-018 Travel limit: direction SHALL be 2'b00 in MOVE_UP when floor[5]=1, and in MOVE_DOWN when floor[0]=1; in that case the next state is IDLE.
REQ-019 DOOR_OPEN: door_open=1 and the dwell counter loads DOOR_CYCLES-1 on entry and decrements each cycle. When it reaches 0, the next state is chosen as follows:
  - sweep=UP: above -> MOVE_UP; else below -> MOVE_DOWN (sweep flips); else IDLE.
  - sweep=DOWN: the mirror of the above.
REQ-020 Exactly DOOR_CYCLES consecutive door_open cycles per stop, absent a reload from REQ-012.
REQ-021 When fault=1, direction SHALL be 2'b00 and the next state SHALL be IDLE. pending SHALL keep latching calls. The dwell counter SHALL clear and door_open SHALL deassert the next cycle.
REQ-022 door_open and a nonzero direction SHALL never be high in the same cycle.

Reset
REQ-023 While reset=0: state=IDLE, sweep=UP, pending=6'b000000, dwell counter=0, door_open=0; direction=2'b00 combinationally.
REQ-024 Reset asserted mid-travel or mid-dwell SHALL drop all calls immediately; operation resumes from IDLE on the first edge after reset deasserts.

Structure
REQ-025 Shared package elevator_pkg SHALL hold:
  - NFLOORS=6;
  - direction constants DIR_UP=2'b10, DIR_DOWN=2'b01, DIR_STOP=2'b00;
  - state enum ctrl_state_t.
REQ-026 The above/below masks and the one-hot check SHALL be combinational logic in the top module.
REQ-027 One sub-module, door_timer, SHALL implement the DOOR_CYCLES dwell counter with load, reload and done signals.

Verification (bench closes the loop through the six-floor floor-light chain; DOOR_CYCLES=4)
REQ-028 Single up call: reset, floor=000001; pulse floorbutton=100000 for one cycle.
  - pending=100000 next cycle.
  - direction=10 for 5 cycles; direction=00 when floor=100000.
  - door_open high for 4 cycles; pending returns to 000000; state IDLE.
REQ-029 Collective sweep: car at 000001; calls 100000 and 000100.
  - Car stops at 000100 first with 4 door cycles, clearing bit 2.
  - Car continues up to 100000; no reversal in between.
REQ-030 Reversal: car at 001000 with sweep=UP; only call 000010.
  - After dwell, the state enters MOVE_DOWN with direction=01.
  - Car stops at floor=000010.
REQ-031 Call at the current floor:
  - Idle at 000100, press 000100: door_open for 4 cycles, direction stays 00.
  - Re-press at the third door cycle: dwell extends to 4 further cycles; pending bit 2 never sets.
REQ-032 Fault and reset:
  - Force floor=000000 mid-travel: fault=1, direction=00, state IDLE, pending retained.
  - Assert reset during DOOR_OPEN: door_open=0 and pending=000000 with no clock edge.
